cordic_sin_0_90: RTL and testbench

- Pipelined CORDIC sine generator for the first quadrant, used as the amplitude stage of the DDS datapath.
- A 7-bit phase address selects an angle in 0..90 degrees; the block returns the 7-bit unsigned sine magnitude.
- Fully pipelined: one new address per clock, fixed 9-cycle latency, no handshake.

---
 rtl/cordic_sin_0_90.sv | 123 ++++++++++++
 tb/tb_cordic_sin_0_90.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cordic_sin_0_90.sv
// First-quadrant CORDIC sine: 7-bit phase address (0..64 => 0..pi/2) to 7-bit magnitude (64 = 1.0).
// Nine register stages: angle setup, seven 2-iteration rotation stages (14 iterations), round/saturate.
module cordic_sin_0_90 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] address,
  output logic [6:0] value
);

  // x/y/z carry 24 fractional bits. The extra fraction bits keep the accumulated
  // truncation error far below the tightest rounding margin (address 16 lands
  // about 0.008 LSB away from a half-step).
  localparam int XW = 28;
  localparam int ZW = 27;
  localparam int FB = 24;
  localparam int ITERS_PER_STAGE = 2;
  localparam int ROT_REGS = 7;

  localparam logic signed [XW-1:0] GAIN_INV   = 28'sd10188014;  // 0.607252935 * 2^24
  localparam logic signed [ZW-1:0] ANGLE_STEP = 27'sd411775;    // pi/128 * 2^24
  localparam logic signed [XW-1:0] ROUND_HALF = 28'sd131072;    // 2^(FB-7)
  localparam logic signed [XW-1:0] OUT_MAX    = 28'sd64;

  typedef struct packed {
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;
    logic signed [ZW-1:0] z;
  } cs_t;

  // atan(2^-i) * 2^24, rounded to nearest
  function automatic logic signed [ZW-1:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 27'sd13176795;
      1:       atan_lut = 27'sd7778716;
      2:       atan_lut = 27'sd4110060;
      3:       atan_lut = 27'sd2086331;
      4:       atan_lut = 27'sd1047214;
      5:       atan_lut = 27'sd524117;
      6:       atan_lut = 27'sd262123;
      7:       atan_lut = 27'sd131069;
      8:       atan_lut = 27'sd65536;
      9:       atan_lut = 27'sd32768;
      10:      atan_lut = 27'sd16384;
      11:      atan_lut = 27'sd8192;
      12:      atan_lut = 27'sd4096;
      13:      atan_lut = 27'sd2048;
      default: atan_lut = '0;
    endcase
  endfunction

  function automatic cs_t rotate(input cs_t a, input int i);
    cs_t r;
    logic signed [XW-1:0] xs;
    logic signed [XW-1:0] ys;
    xs = $signed(a.x) >>> i;
    ys = $signed(a.y) >>> i;
    if (a.z[ZW-1]) begin
      r.x = a.x + ys;
      r.y = a.y - xs;
      r.z = a.z + atan_lut(i);
    end else begin
      r.x = a.x - ys;
      r.y = a.y + xs;
      r.z = a.z - atan_lut(i);
    end
    return r;
  endfunction

  function automatic cs_t rotate2(input cs_t a, input int i);
    return rotate(rotate(a, i), i + 1);
  endfunction

  // The final rotation stage only needs to hand y onward.
  function automatic logic signed [XW-1:0] rotate2_y(input cs_t a, input int i);
    cs_t r;
    r = rotate2(a, i);
    return r.y;
  endfunction

  logic [6:0]           addr_clamped;
  logic signed [ZW-1:0] angle;
  cs_t                  pipe_q [ROT_REGS];
  logic signed [XW-1:0] y_last_q;
  logic signed [XW-1:0] y_rounded;
  logic [6:0]           value_next;

  always_comb begin
    addr_clamped = (address > 7'd64) ? 7'd64 : address;
    angle        = $signed({20'd0, addr_clamped}) * ANGLE_STEP;
  end

  always_comb begin
    y_rounded  = (y_last_q + ROUND_HALF) >>> (FB - 6);
    value_next = '0;
    if (y_rounded < 0) begin
      value_next = '0;
    end else if (y_rounded > OUT_MAX) begin
      value_next = 7'd64;
    end else begin
      value_next = y_rounded[6:0];
    end
  end

  // pipe_q[0] is the angle-setup stage; pipe_q[1..6] hold iterations 0..11,
  // y_last_q holds iterations 12..13, value is the round/saturate stage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < ROT_REGS; s++) begin
        pipe_q[s] <= '0;
      end
      y_last_q <= '0;
      value    <= '0;
    end else begin
      pipe_q[0] <= '{x: GAIN_INV, y: '0, z: angle};
      for (int s = 1; s < ROT_REGS; s++) begin
        pipe_q[s] <= rotate2(pipe_q[s-1], ITERS_PER_STAGE * (s - 1));
      end
      y_last_q <= rotate2_y(pipe_q[ROT_REGS-1], ITERS_PER_STAGE * (ROT_REGS - 1));
      value    <= value_next;
    end
  end

endmodule

// File: tb/tb_cordic_sin_0_90.sv
// Self-checking bench for cordic_sin_0_90: directed steps plus random addresses,
// checked against a real-arithmetic sine model behind a 9-deep delay line.
module tb_cordic_sin_0_90;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [6:0] address;
  logic [6:0] value;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  localparam real PI = 3.14159265358979323846;

  cordic_sin_0_90 dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .address (address),
    .value   (value)
  );

  always #5 CLK = ~CLK;

  function automatic int golden(input int a);
    int  c;
    real s;
    c = (a > 64) ? 64 : a;
    s = 64.0 * $sin(real'(c) * PI / 128.0);
    return int'($floor(s + 0.5));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    total++;
    assert (obs === 32'(expv)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: capture what the DUT samples, advance the model, compare after the edge.
  task automatic step(input string tag);
    int   a;
    logic r;
    a = int'(address);
    r = RESET;
    @(posedge CLK);
    if (r) begin
      exp_q = {};
      repeat (9) exp_q.push_back(0);
    end else begin
      exp_q.push_back(golden(a));
      void'(exp_q.pop_front());
    end
    #1;
    check(tag, {25'd0, value}, exp_q[0]);
  endtask

  initial begin
    int hits;
    int first;
    int vals[3];

    repeat (9) exp_q.push_back(0);
    RESET   = 1'b1;
    address = 7'd37;
    #2;

    // reset hold and release with a steady address
    repeat (3) step("reset_hold");
    RESET = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step("reset_release");
      if (i == 8) check("reset_still_zero", {25'd0, value}, 0);
      if (i == 9) check("reset_first", {25'd0, value}, golden(37));
    end

    // ramp 0..64 then flush with zeros
    for (int i = 0; i <= 72; i++) begin
      address = (i <= 64) ? 7'(i) : 7'd0;
      step("ramp");
      case (i - 8)
        0:  check("ramp_a0",  {25'd0, value}, 0);
        1:  check("ramp_a1",  {25'd0, value}, 2);
        2:  check("ramp_a2",  {25'd0, value}, 3);
        8:  check("ramp_a8",  {25'd0, value}, 12);
        16: check("ramp_a16", {25'd0, value}, 24);
        32: check("ramp_a32", {25'd0, value}, 45);
        48: check("ramp_a48", {25'd0, value}, 59);
        64: check("ramp_a64", {25'd0, value}, 64);
        default: ;
      endcase
    end

    // single-cycle pulse: exact latency and width
    address = 7'd0;
    repeat (10) step("lat_idle");
    address = 7'd32;
    step("lat_pulse");
    address = 7'd0;
    hits  = 0;
    first = -1;
    for (int j = 1; j <= 14; j++) begin
      step("lat_after");
      if (value == 7'd45) begin
        hits++;
        if (first < 0) first = j;
      end
    end
    check("lat_count", 32'(hits), 1);
    check("lat_pos", 32'(first), 8);

    // out-of-range clamp
    vals = '{65, 100, 127};
    for (int c = 0; c < 3; c++) begin
      address = 7'(vals[c]);
      step("clamp_in");
    end
    address = 7'd0;
    for (int j = 1; j <= 10; j++) begin
      step("clamp_flush");
      if (j >= 6 && j <= 8) check("clamp_val", {25'd0, value}, 64);
    end

    // back-to-back wrap 64 -> 0 -> 1
    vals = '{64, 0, 1};
    for (int c = 0; c < 3; c++) begin
      address = 7'(vals[c]);
      step("wrap_in");
    end
    address = 7'd0;
    for (int j = 1; j <= 10; j++) begin
      step("wrap_flush");
      if (j == 6) check("wrap_64", {25'd0, value}, 64);
      if (j == 7) check("wrap_0",  {25'd0, value}, 0);
      if (j == 8) check("wrap_1",  {25'd0, value}, 2);
    end

    // mid-stream reset during a ramp
    for (int i = 0; i <= 50; i++) begin
      address = (i <= 40) ? 7'(i) : 7'd0;
      RESET   = (i == 20);
      step("midrst");
      if (i == 20) check("midrst_zero", {25'd0, value}, 0);
      if (i == 28) check("midrst_flushed", {25'd0, value}, 0);
      if (i == 29) check("midrst_resume", {25'd0, value}, golden(21));
    end
    RESET = 1'b0;

    // random addresses with occasional resets
    for (int i = 0; i < 300; i++) begin
      address = 7'($urandom_range(0, 127));
      RESET   = ($urandom_range(0, 49) == 0);
      step("random");
    end
    RESET   = 1'b0;
    address = 7'd0;
    repeat (10) step("final_flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
